atm_account_arbiter: RTL and testbench
======================================

Name: atm_account_arbiter

Overview:
Shares one account-balance register between two ATM terminal front-ends. It arbitrates their transaction requests round-robin and executes one transaction at a time: inquiry, withdrawal or deposit. It returns status and the resulting balance over a four-phase req/ack handshake. It sits between the per-terminal session FSMs and the account balance store.

Parameters:
WIDTH, 16, width of balance and amount datapath
INIT_BALANCE, 16'h2710 (10000), balance loaded at reset
WD_LIMIT, 16'h1388 (5000), maximum single withdrawal amount

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset
req  input  2  per-terminal transaction request; bit i = terminal i
op0  input  2  terminal 0 opcode: 00 inquiry, 01 withdraw, 10 deposit, 11 reserved
amt0  input  WIDTH  terminal 0 amount
op1  input  2  terminal 1 opcode, same encoding as op0
amt1  input  WIDTH  terminal 1 amount
ack  output  2  per-terminal acknowledge; bit i = terminal i
status  output  2  result: 00 OK, 01 INSUFFICIENT, 10 LIMIT, 11 BAD_OP
rd_balance  output  WIDTH  balance after the transaction
balance  output  WIDTH  live account balance
busy  output  1  high whenever state is not IDLE

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (reset); polarity and synchronicity are fixed.
- Reset (reset==0 at a clk edge): state=IDLE, balance=INIT_BALANCE, ack=00, status=00, rd_balance=0, busy=0, last_grant=1 (terminal 0 wins the first contention). Reset applies in any state and aborts any in-flight transaction without committing it.
- States: IDLE, EXEC, WAIT_REL.
- IDLE:
  - If any req bit is set, select grant id g. With a single requester, g is that requester. With both requesting, g = ~last_grant.
  - Capture g, op_g and amt_g into internal registers; last_grant<=g; go to EXEC.
  - Opcode and amount are sampled only here. Later input changes are ignored.
- EXEC (one cycle), evaluated on captured values:
  - Inquiry: status=OK; balance unchanged.
  - Withdraw:
    - amt > WD_LIMIT: status=LIMIT.
    - Otherwise, amt > balance: status=INSUFFICIENT.
    - Otherwise: balance<=balance-amt, status=OK.
    - Check order: LIMIT before INSUFFICIENT.
  - Deposit: compute the sum at WIDTH+1 bits. If the carry bit is set, status=LIMIT and balance is unchanged. Otherwise balance<=sum, status=OK.
  - Reserved op (11): status=BAD_OP; balance unchanged.
  - rd_balance<=the post-transaction balance value (the old balance on any non-OK status).
  - ack[g]<=1; go to WAIT_REL.
- WAIT_REL:
  - ack[g] and status/rd_balance are held stable while req[g]==1.
  - When req[g]==0: ack<=00, go to IDLE.
  - A terminal must not reassert req until its ack has dropped.
- Latency: req[g] sampled high at edge k (IDLE), balance updated and ack[g] high after edge k+1, ack low one edge after req[g] is sampled low.
- Amount 0: withdraw and deposit return OK with balance unchanged.
- Boundary cases:
  - Withdraw with amt==balance (and ≤ WD_LIMIT) returns OK and leaves balance=0.
  - Withdraw with amt==WD_LIMIT is allowed.
- Protocol violation: if req[g] drops during EXEC, the transaction still commits. ack[g] pulses for exactly one cycle, then the block returns to IDLE.
- A request from the non-granted terminal waits; it is serviced in the next IDLE cycle. Maximum wait is one transaction.
- ack is one-hot or zero; both bits are never high at once.

Test Plan:
- After reset release, req=01, op0=00 -> ack=01 two edges later, status=00, rd_balance=10000; drop req -> ack=00, busy=0.
- Terminal 0 withdraws 3000 -> status=00, balance=7000. Terminal 1 then withdraws 5001 -> status=10, balance stays 7000.
- balance=7000, withdraw 5000 twice -> first OK (2000), second INSUFFICIENT, rd_balance=2000.
- Deposit 65535-10000+1 from reset balance -> LIMIT, balance 10000. Deposit 55535 -> OK, balance 65535.
- req=11 asserted together from IDLE, repeated three times -> grants alternate 0,1,0. ack is never 11.
- Reset low during WAIT_REL after a withdrawal of 1000 -> next cycle ack=00, state IDLE, balance=10000.
- op=11 -> status=11, balance unchanged. A req drop during EXEC still commits and gives a one-cycle ack.

Source files
------------

// File: rtl/atm_account_arbiter_if.sv
// Terminal-facing transaction bus of the ATM account arbiter.
// The master is the terminal side and the slave is the arbiter.
interface atm_account_arbiter_if #(
  parameter int unsigned WIDTH = 16
);
  logic [1:0]       req;
  logic [1:0]       op0;
  logic [WIDTH-1:0] amt0;
  logic [1:0]       op1;
  logic [WIDTH-1:0] amt1;
  logic [1:0]       ack;
  logic [1:0]       status;
  logic [WIDTH-1:0] rd_balance;
  logic [WIDTH-1:0] balance;
  logic             busy;

  modport master (
    output req, op0, amt0, op1, amt1,
    input  ack, status, rd_balance, balance, busy
  );

  modport slave (
    input  req, op0, amt0, op1, amt1,
    output ack, status, rd_balance, balance, busy
  );
endinterface

// File: rtl/atm_account_arbiter.sv
// Round-robin arbiter that runs inquiry/withdraw/deposit transactions from
// two ATM terminals against one shared balance, with a four-phase req/ack.
module atm_account_arbiter #(
  parameter int unsigned      WIDTH        = 16,
  parameter logic [WIDTH-1:0] INIT_BALANCE = WIDTH'(16'h2710),
  parameter logic [WIDTH-1:0] WD_LIMIT     = WIDTH'(16'h1388)
) (
  input logic                  clk,
  input logic                  reset,
  atm_account_arbiter_if.slave bus
);

  localparam logic [1:0] OP_INQ = 2'b00;
  localparam logic [1:0] OP_WD  = 2'b01;
  localparam logic [1:0] OP_DEP = 2'b10;

  localparam logic [1:0] ST_OK     = 2'b00;
  localparam logic [1:0] ST_INSUFF = 2'b01;
  localparam logic [1:0] ST_LIMIT  = 2'b10;
  localparam logic [1:0] ST_BADOP  = 2'b11;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    EXEC     = 2'b01,
    WAIT_REL = 2'b10
  } state_t;

  state_t           state, state_next;
  logic             grant, grant_next;
  logic             last_grant, last_grant_next;
  logic [1:0]       op_q, op_next;
  logic [WIDTH-1:0] amt_q, amt_next;
  logic [WIDTH-1:0] balance_q, balance_next;
  logic [1:0]       ack_q, ack_next;
  logic [1:0]       status_q, status_next;
  logic [WIDTH-1:0] rd_balance_q, rd_balance_next;
  logic             busy_q, busy_next;
  logic [WIDTH:0]   sum;
  logic             g;

  // State and datapath registers; reset aborts any in-flight transaction.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      grant        <= 1'b0;
      last_grant   <= 1'b1;
      op_q         <= OP_INQ;
      amt_q        <= '0;
      balance_q    <= INIT_BALANCE;
      ack_q        <= 2'b00;
      status_q     <= ST_OK;
      rd_balance_q <= '0;
      busy_q       <= 1'b0;
    end else begin
      state        <= state_next;
      grant        <= grant_next;
      last_grant   <= last_grant_next;
      op_q         <= op_next;
      amt_q        <= amt_next;
      balance_q    <= balance_next;
      ack_q        <= ack_next;
      status_q     <= status_next;
      rd_balance_q <= rd_balance_next;
      busy_q       <= busy_next;
    end
  end

  // Next-state, arbitration and transaction evaluation.
  always_comb begin
    state_next      = state;
    grant_next      = grant;
    last_grant_next = last_grant;
    op_next         = op_q;
    amt_next        = amt_q;
    balance_next    = balance_q;
    ack_next        = ack_q;
    status_next     = status_q;
    rd_balance_next = rd_balance_q;
    sum             = {1'b0, balance_q} + {1'b0, amt_q};
    g               = (bus.req == 2'b11) ? ~last_grant : bus.req[1];

    unique case (state)
      IDLE: begin
        if (|bus.req) begin
          grant_next      = g;
          last_grant_next = g;
          op_next         = g ? bus.op1 : bus.op0;
          amt_next        = g ? bus.amt1 : bus.amt0;
          state_next      = EXEC;
        end
      end
      EXEC: begin
        unique case (op_q)
          OP_INQ: status_next = ST_OK;
          OP_WD: begin
            if (amt_q > WD_LIMIT) begin
              status_next = ST_LIMIT;
            end else if (amt_q > balance_q) begin
              status_next = ST_INSUFF;
            end else begin
              balance_next = balance_q - amt_q;
              status_next  = ST_OK;
            end
          end
          OP_DEP: begin
            // Carry out of the widened sum means the balance would wrap.
            if (sum[WIDTH]) begin
              status_next = ST_LIMIT;
            end else begin
              balance_next = sum[WIDTH-1:0];
              status_next  = ST_OK;
            end
          end
          default: status_next = ST_BADOP;
        endcase
        rd_balance_next  = balance_next;
        ack_next         = 2'b00;
        ack_next[grant]  = 1'b1;
        state_next       = WAIT_REL;
      end
      WAIT_REL: begin
        if (!bus.req[grant]) begin
          ack_next   = 2'b00;
          state_next = IDLE;
        end
      end
      default: begin
        ack_next   = 2'b00;
        state_next = IDLE;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

  assign bus.ack        = ack_q;
  assign bus.status     = status_q;
  assign bus.rd_balance = rd_balance_q;
  assign bus.balance    = balance_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_atm_account_arbiter.sv
// Directed bench for atm_account_arbiter: each task drives one scenario
// and checks hand-computed status/balance/ack values.
module tb_atm_account_arbiter;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  atm_account_arbiter_if #(.WIDTH(16)) bus ();

  atm_account_arbiter #(
    .WIDTH        (16),
    .INIT_BALANCE (16'h2710),
    .WD_LIMIT     (16'h1388)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset();
    @(posedge clk); #1;
    reset    = 1'b0;
    bus.req  = 2'b00;
    bus.op0  = 2'b00;
    bus.op1  = 2'b00;
    bus.amt0 = 16'd0;
    bus.amt1 = 16'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  // Drives one transaction, scrambles the inputs once captured, then releases.
  task automatic run_txn(input int t, input logic [1:0] op, input logic [15:0] amt,
                         output logic [1:0] st, output logic [15:0] rb, output int lat);
    bit got;
    if (t == 0) begin bus.op0 = op; bus.amt0 = amt; end
    else        begin bus.op1 = op; bus.amt1 = amt; end
    bus.req[t] = 1'b1;
    got = 0;
    lat = 0;
    for (int i = 1; i <= 10 && !got; i++) begin
      @(posedge clk); #1;
      if (bus.ack[t]) begin got = 1; lat = i; end
      if (i == 1) begin
        if (t == 0) begin bus.op0 = 2'b11; bus.amt0 = 16'hFFFF; end
        else        begin bus.op1 = 2'b11; bus.amt1 = 16'hFFFF; end
      end
    end
    n_cmp++;
    if (!got) begin
      n_err++;
      $display("FAIL ack_timeout t%0d: ack=%b required ack bit %0d high", t, bus.ack, t);
    end
    st = bus.status;
    rb = bus.rd_balance;
    bus.req[t] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp += 5;
    if (bus.ack !== 2'b00) begin n_err++; $display("FAIL reset_ack: got %b want 00", bus.ack); end
    if (bus.status !== 2'b00) begin n_err++; $display("FAIL reset_status: got %b want 00", bus.status); end
    if (bus.rd_balance !== 16'd0) begin n_err++; $display("FAIL reset_rd_balance: got %0d want 0", bus.rd_balance); end
    if (bus.balance !== 16'd10000) begin n_err++; $display("FAIL reset_balance: got %0d want 10000", bus.balance); end
    if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_inquiry();
    logic [1:0] st; logic [15:0] rb; int lat;
    apply_reset();
    run_txn(0, 2'b00, 16'd0, st, rb, lat);
    n_cmp += 5;
    if (lat !== 2) begin n_err++; $display("FAIL inq_latency: got %0d want 2", lat); end
    if (st !== 2'b00) begin n_err++; $display("FAIL inq_status: got %b want 00", st); end
    if (rb !== 16'd10000) begin n_err++; $display("FAIL inq_rd_balance: got %0d want 10000", rb); end
    if (bus.ack !== 2'b00) begin n_err++; $display("FAIL inq_ack_release: got %b want 00", bus.ack); end
    if (bus.busy !== 1'b0) begin n_err++; $display("FAIL inq_busy_release: got %b want 0", bus.busy); end
  endtask

  task automatic test_withdraw_limit();
    logic [1:0] st; logic [15:0] rb; int lat;
    apply_reset();
    run_txn(0, 2'b01, 16'd3000, st, rb, lat);
    n_cmp += 2;
    if (st !== 2'b00) begin n_err++; $display("FAIL wd3000_status: got %b want 00", st); end
    if (bus.balance !== 16'd7000) begin n_err++; $display("FAIL wd3000_balance: got %0d want 7000", bus.balance); end
    run_txn(1, 2'b01, 16'd5001, st, rb, lat);
    n_cmp += 3;
    if (st !== 2'b10) begin n_err++; $display("FAIL wd5001_status: got %b want 10", st); end
    if (rb !== 16'd7000) begin n_err++; $display("FAIL wd5001_rd_balance: got %0d want 7000", rb); end
    if (bus.balance !== 16'd7000) begin n_err++; $display("FAIL wd5001_balance: got %0d want 7000", bus.balance); end
    // Balance is 7000 here: two 5000 withdrawals, the second one short.
    run_txn(0, 2'b01, 16'd5000, st, rb, lat);
    n_cmp += 2;
    if (st !== 2'b00) begin n_err++; $display("FAIL wd5000a_status: got %b want 00", st); end
    if (rb !== 16'd2000) begin n_err++; $display("FAIL wd5000a_rd_balance: got %0d want 2000", rb); end
    run_txn(0, 2'b01, 16'd5000, st, rb, lat);
    n_cmp += 2;
    if (st !== 2'b01) begin n_err++; $display("FAIL wd5000b_status: got %b want 01", st); end
    if (rb !== 16'd2000) begin n_err++; $display("FAIL wd5000b_rd_balance: got %0d want 2000", rb); end
  endtask

  task automatic test_deposit_overflow();
    logic [1:0] st; logic [15:0] rb; int lat;
    apply_reset();
    run_txn(1, 2'b10, 16'd55536, st, rb, lat);
    n_cmp += 2;
    if (st !== 2'b10) begin n_err++; $display("FAIL dep_ovf_status: got %b want 10", st); end
    if (bus.balance !== 16'd10000) begin n_err++; $display("FAIL dep_ovf_balance: got %0d want 10000", bus.balance); end
    run_txn(1, 2'b10, 16'd55535, st, rb, lat);
    n_cmp += 3;
    if (st !== 2'b00) begin n_err++; $display("FAIL dep_max_status: got %b want 00", st); end
    if (rb !== 16'd65535) begin n_err++; $display("FAIL dep_max_rd_balance: got %0d want 65535", rb); end
    if (bus.balance !== 16'd65535) begin n_err++; $display("FAIL dep_max_balance: got %0d want 65535", bus.balance); end
  endtask

  task automatic test_boundary();
    logic [1:0] st; logic [15:0] rb; int lat;
    apply_reset();
    run_txn(0, 2'b01, 16'd5000, st, rb, lat);
    n_cmp += 2;
    if (st !== 2'b00) begin n_err++; $display("FAIL wd_eq_limit_status: got %b want 00", st); end
    if (rb !== 16'd5000) begin n_err++; $display("FAIL wd_eq_limit_rd_balance: got %0d want 5000", rb); end
    run_txn(1, 2'b01, 16'd5000, st, rb, lat);
    n_cmp += 2;
    if (st !== 2'b00) begin n_err++; $display("FAIL wd_eq_bal_status: got %b want 00", st); end
    if (bus.balance !== 16'd0) begin n_err++; $display("FAIL wd_eq_bal_balance: got %0d want 0", bus.balance); end
    run_txn(0, 2'b10, 16'd0, st, rb, lat);
    n_cmp += 2;
    if (st !== 2'b00) begin n_err++; $display("FAIL dep_zero_status: got %b want 00", st); end
    if (rb !== 16'd0) begin n_err++; $display("FAIL dep_zero_rd_balance: got %0d want 0", rb); end
    run_txn(0, 2'b01, 16'd0, st, rb, lat);
    n_cmp += 2;
    if (st !== 2'b00) begin n_err++; $display("FAIL wd_zero_status: got %b want 00", st); end
    if (bus.balance !== 16'd0) begin n_err++; $display("FAIL wd_zero_balance: got %0d want 0", bus.balance); end
  endtask

  task automatic test_contention();
    logic [1:0] exp;
    bit got;
    int waited;
    apply_reset();
    bus.op0 = 2'b00;
    bus.op1 = 2'b00;
    for (int r = 0; r < 4; r++) begin
      exp = (r % 2 == 0) ? 2'b01 : 2'b10;
      bus.req = 2'b11;
      got = 0;
      for (int i = 0; i < 10 && !got; i++) begin
        @(posedge clk); #1;
        n_cmp++;
        if (bus.ack === 2'b11) begin n_err++; $display("FAIL ack_both_high round %0d: got %b", r, bus.ack); end
        if (bus.ack !== 2'b00) got = 1;
      end
      n_cmp++;
      if (bus.ack !== exp) begin n_err++; $display("FAIL grant_round%0d: got %b want %b", r, bus.ack, exp); end
      if (r < 3) begin
        bus.req = 2'b00;
        @(posedge clk); #1;
      end
    end
    // Round 3 granted terminal 1; terminal 0 keeps waiting and must be served next.
    bus.req[1] = 1'b0;
    got = 0;
    waited = 0;
    for (int i = 1; i <= 10 && !got; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (bus.ack === 2'b11) begin n_err++; $display("FAIL ack_both_high waiter: got %b", bus.ack); end
      if (bus.ack[0]) begin got = 1; waited = i; end
    end
    n_cmp++;
    if (waited !== 3) begin n_err++; $display("FAIL waiter_latency: got %0d want 3", waited); end
    bus.req = 2'b00;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_wait_rel();
    bit got;
    apply_reset();
    bus.op0  = 2'b01;
    bus.amt0 = 16'd1000;
    bus.req  = 2'b01;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(posedge clk); #1;
      if (bus.ack[0]) got = 1;
    end
    n_cmp += 2;
    if (!got) begin n_err++; $display("FAIL rst_wr_ack_timeout: ack=%b want 01", bus.ack); end
    if (bus.balance !== 16'd9000) begin n_err++; $display("FAIL rst_wr_pre_balance: got %0d want 9000", bus.balance); end
    reset = 1'b0;
    @(posedge clk); #1;
    n_cmp += 3;
    if (bus.ack !== 2'b00) begin n_err++; $display("FAIL rst_wr_ack: got %b want 00", bus.ack); end
    if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rst_wr_busy: got %b want 0", bus.busy); end
    if (bus.balance !== 16'd10000) begin n_err++; $display("FAIL rst_wr_balance: got %0d want 10000", bus.balance); end
    bus.req = 2'b00;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic test_badop_and_drop();
    logic [1:0] st; logic [15:0] rb; int lat;
    apply_reset();
    run_txn(0, 2'b11, 16'd1234, st, rb, lat);
    n_cmp += 3;
    if (st !== 2'b11) begin n_err++; $display("FAIL badop_status: got %b want 11", st); end
    if (rb !== 16'd10000) begin n_err++; $display("FAIL badop_rd_balance: got %0d want 10000", rb); end
    if (bus.balance !== 16'd10000) begin n_err++; $display("FAIL badop_balance: got %0d want 10000", bus.balance); end
    // Terminal 1 withdraws 100 and drops req while the arbiter is in EXEC.
    bus.op1  = 2'b01;
    bus.amt1 = 16'd100;
    bus.req  = 2'b10;
    @(posedge clk); #1;
    bus.req = 2'b00;
    @(posedge clk); #1;
    n_cmp += 3;
    if (bus.ack !== 2'b10) begin n_err++; $display("FAIL drop_ack_pulse: got %b want 10", bus.ack); end
    if (bus.balance !== 16'd9900) begin n_err++; $display("FAIL drop_balance: got %0d want 9900", bus.balance); end
    if (bus.status !== 2'b00) begin n_err++; $display("FAIL drop_status: got %b want 00", bus.status); end
    @(posedge clk); #1;
    n_cmp += 2;
    if (bus.ack !== 2'b00) begin n_err++; $display("FAIL drop_ack_end: got %b want 00", bus.ack); end
    if (bus.busy !== 1'b0) begin n_err++; $display("FAIL drop_busy_end: got %b want 0", bus.busy); end
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    reset    = 1'b0;
    bus.req  = 2'b00;
    bus.op0  = 2'b00;
    bus.op1  = 2'b00;
    bus.amt0 = 16'd0;
    bus.amt1 = 16'd0;
    test_reset();
    test_inquiry();
    test_withdraw_limit();
    test_deposit_overflow();
    test_boundary();
    test_contention();
    test_reset_wait_rel();
    test_badop_and_drop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
